// File: rtl/data_ram_write_arbiter_pkg.sv
// data_ram_write_arbiter_pkg: shared state codes and widths for the RAM write arbiter
package data_ram_write_arbiter_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_CORE      = 2'd1,
    ST_HOST      = 2'd2,
    ST_HOST_LOCK = 2'd3
  } state_t;
endpackage

// File: rtl/data_ram_write_arbiter_burst_limit_counter.sv
// burst_limit_counter: saturating count of consecutive locked host grants
module burst_limit_counter #(
  parameter int MAX_BURST = 8,
  parameter int CW = $clog2(MAX_BURST + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iClear,
  input  logic          iIncr,
  output logic [CW-1:0] oCount,
  output logic          oLimitReached
);
  logic [CW-1:0] count_q, count_d;
  assign oLimitReached = count_q == CW'(MAX_BURST);
  assign oCount = count_q;
  // Clear wins over increment; increment stops at the limit instead of wrapping
  always_comb count_d = iClear ? '0 : (iIncr && !oLimitReached) ? count_q + CW'(1) : count_q;
  // Count register
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/data_ram_write_arbiter.sv
// data_ram_write_arbiter: shares the data RAM write port between core and host; ARB_ROUND_ROBIN_EN selects round-robin on contention
module data_ram_write_arbiter
  import data_ram_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCoreReq,
  input  logic [ADDR_WIDTH-1:0] iCoreAddr,
  input  logic [DATA_WIDTH-1:0] iCoreData,
  output logic                  oCoreAck,
  output logic                  oCoreStall,
  input  logic                  iHostReq,
  input  logic                  iHostLock,
  input  logic [ADDR_WIDTH-1:0] iHostAddr,
  input  logic [DATA_WIDTH-1:0] iHostData,
  output logic                  oHostAck,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataIn,
  output logic [STATE_W-1:0]    oOwner
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t state_q, state_d;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0] count;
  logic limit, lock_active, core_pref, grant_core, grant_host, cnt_incr;
  burst_limit_counter #(.MAX_BURST(MAX_BURST), .CW(CW)) u_cnt (
    .Clock(Clock),
    .Reset(Reset),
    .iClear(!cnt_incr),
    .iIncr(cnt_incr),
    .oCount(count),
    .oLimitReached(limit)
  );
`ifdef ARB_ROUND_ROBIN_EN
  assign core_pref = state_q != ST_CORE;
`else
  assign core_pref = 1'b1;
`endif
  // Grant decision, next state and next write-port contents
  always_comb begin
    lock_active = state_q == ST_HOST_LOCK && iHostReq && iHostLock && !limit;
    grant_core = iCoreReq && !lock_active && (!iHostReq || core_pref);
    grant_host = iHostReq && !grant_core;
    cnt_incr = grant_host && iHostLock;
    state_d = grant_core ? ST_CORE : grant_host ? (iHostLock ? ST_HOST_LOCK : ST_HOST) : ST_IDLE;
    we_d = grant_core || grant_host;
    addr_d = grant_core ? iCoreAddr : grant_host ? iHostAddr : addr_q;
    data_d = grant_core ? iCoreData : grant_host ? iHostData : data_q;
  end
  assign oCoreAck = grant_core;
  assign oHostAck = grant_host;
  assign oCoreStall = iCoreReq && !grant_core;
  assign oWriteEnable = we_q;
  assign oWriteAddress = addr_q;
  assign oDataIn = data_q;
  assign oOwner = state_q;
  // State and registered RAM write port
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state_q <= ST_IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
endmodule

// File: tb/tb_data_ram_write_arbiter.sv
// tb_data_ram_write_arbiter: directed and random checks against a behavioural arbiter model
module tb_data_ram_write_arbiter;
  localparam int MAX_BURST = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic Clock = 0, Reset = 1;
  logic iCoreReq = 0, iHostReq = 0, iHostLock = 0;
  logic [7:0] iCoreAddr = 0, iHostAddr = 0;
  logic [15:0] iCoreData = 0, iHostData = 0;
  logic oCoreAck, oCoreStall, oHostAck, oWriteEnable;
  logic [7:0] oWriteAddress;
  logic [15:0] oDataIn;
  logic [1:0] oOwner;
  int checks = 0, errors = 0;
  int m_last = 0, m_burst = 0;
  logic e_we = 0;
  logic [7:0] e_addr = 0;
  logic [15:0] e_data = 0;
  logic last_c, last_h;
  int host_acks, first_core;

  data_ram_write_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MAX_BURST(MAX_BURST)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCoreReq(iCoreReq), .iCoreAddr(iCoreAddr), .iCoreData(iCoreData),
    .oCoreAck(oCoreAck), .oCoreStall(oCoreStall),
    .iHostReq(iHostReq), .iHostLock(iHostLock), .iHostAddr(iHostAddr), .iHostData(iHostData),
    .oHostAck(oHostAck), .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oDataIn(oDataIn), .oOwner(oOwner)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_burst = 0; e_we = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, oWriteEnable, 0);
    chk({tag, "_addr"}, oWriteAddress, 0);
    chk({tag, "_data"}, oDataIn, 0);
    chk({tag, "_owner"}, oOwner, 0);
  endtask

  task automatic step(input logic cr, input logic [7:0] ca, input logic [15:0] cd,
                      input logic hr, input logic hl, input logic [7:0] ha, input logic [15:0] hd);
    logic ec, eh;
    iCoreReq = cr; iCoreAddr = ca; iCoreData = cd;
    iHostReq = hr; iHostLock = hl; iHostAddr = ha; iHostData = hd;
    #1;
    if (m_last == 3 && hr && hl && m_burst < MAX_BURST) begin
      ec = 0; eh = 1;
    end else if (cr && hr) begin
      ec = !(RR && m_last == 1); eh = !ec;
    end else begin
      ec = cr; eh = hr;
    end
    chk("core_ack", oCoreAck, ec);
    chk("host_ack", oHostAck, eh);
    chk("core_stall", oCoreStall, cr && !ec);
    last_c = ec; last_h = eh;
    @(posedge Clock);
    if (ec) begin
      m_last = 1; m_burst = 0; e_we = 1; e_addr = ca; e_data = cd;
    end else if (eh) begin
      m_last = hl ? 3 : 2;
      m_burst = hl ? (m_burst < MAX_BURST ? m_burst + 1 : MAX_BURST) : 0;
      e_we = 1; e_addr = ha; e_data = hd;
    end else begin
      m_last = 0; m_burst = 0; e_we = 0;
    end
    @(negedge Clock);
    chk("we", oWriteEnable, e_we);
    if (e_we) begin
      chk("addr", oWriteAddress, e_addr);
      chk("data", oDataIn, e_data);
    end
    chk("owner", oOwner, m_last[1:0]);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    chk_zero("reset");
    @(negedge Clock);
    Reset = 0;
    model_reset();
    step(1, 8'h05, 16'h1234, 0, 0, 0, 0);
    chk("t2_ack", last_c, 1);
    chk("t2_addr", oWriteAddress, 8'h05);
    chk("t2_data", oDataIn, 16'h1234);
    idle();
    chk("t2_we_off", oWriteEnable, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h10 + 8'(i), 16'hA000 + 16'(i), 1, 0, 8'h20, 16'hBEEF);
`ifndef ARB_ROUND_ROBIN_EN
      chk("t3_core_wins", last_c, 1);
`endif
    end
    step(0, 0, 0, 1, 0, 8'h20, 16'hBEEF);
    chk("t3_host_after", last_h, 1);
    idle();
    host_acks = 0; first_core = 0;
    for (int i = 1; i <= 10; i++) begin
      step(i >= 2, 8'h33, 16'h5555, 1, 1, 8'(8'h40 + i), 16'(i));
      if (last_h) host_acks++;
      if (last_c && first_core == 0) first_core = i;
    end
    chk("t4_host_acks", host_acks, 8);
    chk("t4_core_cycle", first_core, 9);
    idle();
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h01, 16'h0001, 1, 0, 8'h02, 16'h0002);
      chk("t5_rr", last_c, (i % 2) == 0);
    end
    idle();
`endif
    step(0, 0, 0, 1, 1, 8'h61, 16'h0061);
    step(0, 0, 0, 1, 1, 8'h62, 16'h0062);
    iHostAddr = 8'h63; iHostData = 16'h0063;
    #1;
    chk("t6_third_ack", oHostAck, 1);
    #1 Reset = 1;
    #1;
    chk_zero("t6_async");
    @(posedge Clock);
    #1;
    chk_zero("t6_after_edge");
    @(negedge Clock);
    Reset = 0;
    iHostReq = 0; iHostLock = 0;
    model_reset();
    for (int i = 0; i < MAX_BURST; i++) step(0, 0, 0, 1, 1, 8'(8'h70 + i), 16'(i));
    step(1, 8'h7F, 16'h7777, 1, 1, 8'h80, 16'h0080);
    chk("t6_count_cleared", last_c, 1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
